// File: rtl/fat32_pkg.sv
// FAT32 boot-sector layout constants and parser state encoding.
// Offsets are byte positions within the 512-byte volume boot record.
package fat32_pkg;

  localparam logic [9:0] OFS_BPS      = 10'd11;
  localparam logic [9:0] OFS_SPC      = 10'd13;
  localparam logic [9:0] OFS_RSVD     = 10'd14;
  localparam logic [9:0] OFS_NFATS    = 10'd16;
  localparam logic [9:0] OFS_FATSZ    = 10'd36;
  localparam logic [9:0] OFS_ROOTCLUS = 10'd44;
  localparam logic [9:0] OFS_SIG      = 10'd510;

  localparam logic [7:0] SIG_LO = 8'h55;
  localparam logic [7:0] SIG_HI = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CHECK,
    CALC,
    DONE
  } bpb_state_t;

endpackage

// File: rtl/fat32_bpb_parser_if.sv
// Byte stream from the SD controller into the BPB parser.
// master = SD controller side, slave = parser side.
interface fat32_bpb_parser_if;
  logic [7:0] incoming_byte;
  logic       finished_byte;
  logic       finished_block;

  modport master (
    output incoming_byte,
    output finished_byte,
    output finished_block
  );

  modport slave (
    input incoming_byte,
    input finished_byte,
    input finished_block
  );
endinterface

// File: rtl/fat32_bpb_parser.sv
// Extracts FAT32 BPB fields from the boot sector stream and
// derives the first-FAT and cluster-2 LBAs with one shared adder.
module fat32_bpb_parser
  import fat32_pkg::*;
#(
  parameter int SECTOR_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] partition_lba,
  fat32_bpb_parser_if.slave sd,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        error,
  output logic [15:0] bytes_per_sector,
  output logic [7:0]  sectors_per_cluster,
  output logic [15:0] reserved_sectors,
  output logic [7:0]  num_fats,
  output logic [31:0] fat_size,
  output logic [31:0] root_cluster,
  output logic [31:0] fat_begin_lba,
  output logic [31:0] cluster_begin_lba
);

  localparam logic [9:0]  NBYTES = 10'(SECTOR_BYTES);
  localparam logic [15:0] BPS_OK = 16'(SECTOR_BYTES);

  bpb_state_t  state;
  bpb_state_t  state_nxt;
  logic [9:0]  idx;
  logic [31:0] plba;
  logic [7:0]  sig_lo;
  logic [7:0]  sig_hi;
  logic [7:0]  cnt;
  logic        chk_ok;
  logic        spc_pow2;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] sum;

  always_comb begin
    spc_pow2 = (sectors_per_cluster != 8'd0) &&
      ((sectors_per_cluster &
        (sectors_per_cluster - 8'd1)) == 8'd0);
    chk_ok = (idx == NBYTES) &&
      (sig_lo == SIG_LO) &&
      (sig_hi == SIG_HI) &&
      (bytes_per_sector == BPS_OK) &&
      spc_pow2 &&
      (num_fats != 8'd0);
  end

  // CHECK seeds with partition+reserved; CALC accumulates fat_size.
  always_comb begin
    add_a = cluster_begin_lba;
    add_b = fat_size;
    if (state == CHECK) begin
      add_a = plba;
      add_b = {16'd0, reserved_sectors};
    end
    sum = add_a + add_b;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CAPTURE;
      CAPTURE: if (sd.finished_block) state_nxt = CHECK;
      CHECK:   state_nxt = chk_ok ? CALC : DONE;
      CALC:    if (cnt == 8'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CAPTURE) ||
           (state == CHECK) ||
           (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx                 <= '0;
      plba                <= '0;
      sig_lo              <= '0;
      sig_hi              <= '0;
      cnt                 <= '0;
      valid               <= 1'b0;
      error               <= 1'b0;
      bytes_per_sector    <= '0;
      sectors_per_cluster <= '0;
      reserved_sectors    <= '0;
      num_fats            <= '0;
      fat_size            <= '0;
      root_cluster        <= '0;
      fat_begin_lba       <= '0;
      cluster_begin_lba   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx                 <= '0;
            plba                <= partition_lba;
            sig_lo              <= '0;
            sig_hi              <= '0;
            cnt                 <= '0;
            valid               <= 1'b0;
            error               <= 1'b0;
            bytes_per_sector    <= '0;
            sectors_per_cluster <= '0;
            reserved_sectors    <= '0;
            num_fats            <= '0;
            fat_size            <= '0;
            root_cluster        <= '0;
            fat_begin_lba       <= '0;
            cluster_begin_lba   <= '0;
          end
        end
        CAPTURE: begin
          if (sd.finished_byte && (idx < NBYTES)) begin
            idx <= idx + 10'd1;
            case (idx)
              OFS_BPS:
                bytes_per_sector[7:0] <= sd.incoming_byte;
              OFS_BPS + 10'd1:
                bytes_per_sector[15:8] <= sd.incoming_byte;
              OFS_SPC:
                sectors_per_cluster <= sd.incoming_byte;
              OFS_RSVD:
                reserved_sectors[7:0] <= sd.incoming_byte;
              OFS_RSVD + 10'd1:
                reserved_sectors[15:8] <= sd.incoming_byte;
              OFS_NFATS:
                num_fats <= sd.incoming_byte;
              OFS_FATSZ:
                fat_size[7:0] <= sd.incoming_byte;
              OFS_FATSZ + 10'd1:
                fat_size[15:8] <= sd.incoming_byte;
              OFS_FATSZ + 10'd2:
                fat_size[23:16] <= sd.incoming_byte;
              OFS_FATSZ + 10'd3:
                fat_size[31:24] <= sd.incoming_byte;
              OFS_ROOTCLUS:
                root_cluster[7:0] <= sd.incoming_byte;
              OFS_ROOTCLUS + 10'd1:
                root_cluster[15:8] <= sd.incoming_byte;
              OFS_ROOTCLUS + 10'd2:
                root_cluster[23:16] <= sd.incoming_byte;
              OFS_ROOTCLUS + 10'd3:
                root_cluster[31:24] <= sd.incoming_byte;
              OFS_SIG:
                sig_lo <= sd.incoming_byte;
              OFS_SIG + 10'd1:
                sig_hi <= sd.incoming_byte;
              default: ;
            endcase
          end
        end
        CHECK: begin
          if (chk_ok) begin
            fat_begin_lba     <= sum;
            cluster_begin_lba <= sum;
            cnt               <= num_fats;
          end else begin
            error <= 1'b1;
          end
        end
        CALC: begin
          cluster_begin_lba <= sum;
          cnt               <= cnt - 8'd1;
          if (cnt == 8'd1) valid <= 1'b1;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fat32_bpb_parser.sv
// Table-driven bench for fat32_bpb_parser with a done-side scoreboard.
module tb_fat32_bpb_parser;

  typedef struct {
    logic [31:0] plba;
    logic [15:0] bps;
    logic [7:0]  spc;
    logic [15:0] rsvd;
    logic [7:0]  nf;
    logic [31:0] fsz;
    logic [31:0] root;
    int          nbytes;
    logic [7:0]  sig_hi;
    bit          same;
    bit          dup;
    bit          ev;
    bit          ee;
    logic [31:0] efat;
    logic [31:0] eclu;
    int          lat;
  } vec_t;

  typedef struct {
    int id;
    vec_t v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] partition_lba = '0;
  logic        busy;
  logic        done;
  logic        valid;
  logic        error;
  logic [15:0] bytes_per_sector;
  logic [7:0]  sectors_per_cluster;
  logic [15:0] reserved_sectors;
  logic [7:0]  num_fats;
  logic [31:0] fat_size;
  logic [31:0] root_cluster;
  logic [31:0] fat_begin_lba;
  logic [31:0] cluster_begin_lba;

  fat32_bpb_parser_if sd_if ();

  fat32_bpb_parser #(.SECTOR_BYTES(512)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .partition_lba       (partition_lba),
    .sd                  (sd_if),
    .busy                (busy),
    .done                (done),
    .valid               (valid),
    .error               (error),
    .bytes_per_sector    (bytes_per_sector),
    .sectors_per_cluster (sectors_per_cluster),
    .reserved_sectors    (reserved_sectors),
    .num_fats            (num_fats),
    .fat_size            (fat_size),
    .root_cluster        (root_cluster),
    .fat_begin_lba       (fat_begin_lba),
    .cluster_begin_lba   (cluster_begin_lba)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   fcyc = 0;
  int   done_cnt = 0;
  exp_t q[$];
  vec_t vecs[10];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sd_if.finished_block) fcyc <= cyc;
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        string p;
        e = q.pop_front();
        p = $sformatf("v%0d_", e.id);
        chk({p, "valid"}, {31'd0, valid}, {31'd0, e.v.ev});
        chk({p, "error"}, {31'd0, error}, {31'd0, e.v.ee});
        chk({p, "busy"}, {31'd0, busy}, 32'd0);
        chk({p, "excl"}, {31'd0, valid & error}, 32'd0);
        chk({p, "fat_lba"}, fat_begin_lba, e.v.efat);
        chk({p, "clu_lba"}, cluster_begin_lba, e.v.eclu);
        chk({p, "bps"}, {16'd0, bytes_per_sector},
            {16'd0, e.v.bps});
        chk({p, "spc"}, {24'd0, sectors_per_cluster},
            {24'd0, e.v.spc});
        chk({p, "rsvd"}, {16'd0, reserved_sectors},
            {16'd0, e.v.rsvd});
        chk({p, "nfats"}, {24'd0, num_fats}, {24'd0, e.v.nf});
        chk({p, "fatsz"}, fat_size, e.v.fsz);
        chk({p, "root"}, root_cluster, e.v.root);
        chk({p, "latency"}, 32'(cyc - fcyc), 32'(e.v.lat));
      end
    end
  end

  function automatic logic [7:0] byte_at(input vec_t v,
                                         input int i);
    logic [31:0] t;
    t = 32'(i * 7 + 3);
    case (i)
      11:  return v.bps[7:0];
      12:  return v.bps[15:8];
      13:  return v.spc;
      14:  return v.rsvd[7:0];
      15:  return v.rsvd[15:8];
      16:  return v.nf;
      36:  return v.fsz[7:0];
      37:  return v.fsz[15:8];
      38:  return v.fsz[23:16];
      39:  return v.fsz[31:24];
      44:  return v.root[7:0];
      45:  return v.root[15:8];
      46:  return v.root[23:16];
      47:  return v.root[31:24];
      510: return 8'h55;
      511: return v.sig_hi;
      default: return t[7:0];
    endcase
  endfunction

  task automatic push(input int id, input vec_t v);
    exp_t e;
    e.id = id;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic begin_parse(input logic [31:0] lba, input int id);
    @(posedge clk); #1;
    start = 1'b1;
    partition_lba = lba;
    @(posedge clk); #1;
    start = 1'b0;
    partition_lba = $urandom;
    chk($sformatf("v%0d_busy_after_start", id), {31'd0, busy}, 32'd1);
  endtask

  task automatic send_bytes(input vec_t v, input int id, input int n);
    for (int i = 0; i < n; i++) begin
      sd_if.incoming_byte = byte_at(v, i);
      sd_if.finished_byte = 1'b1;
      if (v.dup && i == 100) begin
        start = 1'b1;
        partition_lba = 32'd0;
      end
      if (v.same && i == v.nbytes - 1) begin
        sd_if.finished_block = 1'b1;
        push(id, v);
      end
      @(posedge clk); #1;
      sd_if.finished_byte = 1'b0;
      sd_if.finished_block = 1'b0;
      start = 1'b0;
      if (i % 7 == 3) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run(input vec_t v, input int id);
    begin_parse(v.plba, id);
    send_bytes(v, id, v.nbytes);
    if (!v.same) begin
      sd_if.finished_block = 1'b1;
      push(id, v);
      @(posedge clk); #1;
      sd_if.finished_block = 1'b0;
    end
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      chk($sformatf("v%0d_done_timeout", id), 32'd0, 32'd1);
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t g;
    vec_t r;
    int   dc;
    sd_if.incoming_byte = '0;
    sd_if.finished_byte = 1'b0;
    sd_if.finished_block = 1'b0;

    g = '{32'd2048, 16'd512, 8'd8, 16'd32, 8'd2, 32'd961, 32'd2,
          512, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0,
          32'd2080, 32'd4002, 4};
    vecs[0] = g;
    vecs[1] = g;
    vecs[1].sig_hi = 8'h00;
    vecs[2] = g;
    vecs[2].spc = 8'd6;
    vecs[3] = g;
    vecs[3].nf = 8'd0;
    vecs[4] = g;
    vecs[4].bps = 16'd4096;
    vecs[5] = g;
    vecs[5].nbytes = 300;
    vecs[6] = g;
    vecs[6].nbytes = 520;
    vecs[6].same = 1'b1;
    vecs[7] = '{32'hFFFF_FFF0, 16'd512, 8'd1, 16'd32, 8'd1,
                32'd16, 32'd5, 512, 8'hAA, 1'b1, 1'b0, 1'b1,
                1'b0, 32'h10, 32'h20, 3};
    vecs[8] = g;
    vecs[8].dup = 1'b1;
    vecs[9] = '{32'd100, 16'd512, 8'd128, 16'd4, 8'd3, 32'd10,
                32'h0102_0304, 512, 8'hAA, 1'b0, 1'b0, 1'b1,
                1'b0, 32'd104, 32'd134, 5};
    for (int i = 1; i <= 5; i++) begin
      vecs[i].ev = 1'b0;
      vecs[i].ee = 1'b1;
      vecs[i].efat = 32'd0;
      vecs[i].eclu = 32'd0;
      vecs[i].lat = 2;
    end

    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_fat_lba", fat_begin_lba, 32'd0);
    chk("rst_clu_lba", cluster_begin_lba, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    sd_if.finished_byte = 1'b1;
    sd_if.finished_block = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sd_if.finished_byte = 1'b0;
    sd_if.finished_block = 1'b0;
    chk("idle_strobe_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run(vecs[i], i);
      if (i == 0) begin
        r = vecs[0];
        dc = done_cnt;
        begin_parse(r.plba, 100);
        send_bytes(r, 100, 200);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_error", {31'd0, error}, 32'd0);
        chk("midrst_bps", {16'd0, bytes_per_sector}, 32'd0);
        chk("midrst_spc", {24'd0, sectors_per_cluster}, 32'd0);
        chk("midrst_fat_lba", fat_begin_lba, 32'd0);
        chk("midrst_clu_lba", cluster_begin_lba, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt - dc), 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
